// File: rtl/mux_pkg.sv
// Shared definitions for the stream multiplexer family.
// Mode encodings are common to every mux that offers fixed/arbitrated selection.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic logic is_rr_mode(input logic mode);
    return mode == MODE_RR;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester after ptr, wrapping; 0 cycles.
// No state and no backpressure; the caller owns the pointer and decides when it advances.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int SEL_WIDTH = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0]  req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [SEL_WIDTH-1:0] grant,
  output logic                 grant_valid
);

  // Scan farthest-first so the nearest requester after ptr is the last writer.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int off = CHANNELS; off >= 1; off--) begin
      if (req[SEL_WIDTH'((int'(ptr) + off) % CHANNELS)]) begin
        grant       = SEL_WIDTH'((int'(ptr) + off) % CHANNELS);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux, fixed-select or round-robin, 1-cycle registered output.
// Single output register loads whenever empty or draining, so full rate is sustained.
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter int WORDSIZE  = 64,
  parameter int CHANNELS  = 4,
  parameter int SEL_WIDTH = $clog2(CHANNELS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS*WORDSIZE-1:0] in_data,
  input  logic [CHANNELS-1:0]          in_valid,
  output logic [CHANNELS-1:0]          in_ready,
  input  logic                         mode,
  input  logic [SEL_WIDTH-1:0]         sel,
  output logic [WORDSIZE-1:0]          out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SEL_WIDTH-1:0]         out_sel
);

  logic [WORDSIZE-1:0]  r_out_data;
  logic                 r_out_valid;
  logic [SEL_WIDTH-1:0] r_out_sel;
  logic [SEL_WIDTH-1:0] r_ptr;

  logic [WORDSIZE-1:0]  w_words [CHANNELS];
  logic [SEL_WIDTH-1:0] w_rr_grant;
  logic                 w_rr_valid;
  logic                 w_fix_valid;
  logic [SEL_WIDTH-1:0] w_grant;
  logic                 w_grant_valid;
  logic                 w_can_load;
  logic                 w_xfer;
  logic [CHANNELS-1:0]  w_in_ready;

  rr_arbiter #(
    .CHANNELS  (CHANNELS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_arb (
    .req         (in_valid),
    .ptr         (r_ptr),
    .grant       (w_rr_grant),
    .grant_valid (w_rr_valid)
  );

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_words[i] = in_data[i*WORDSIZE +: WORDSIZE];
    end
  end

  // Matching sel against each legal index keeps out-of-range sel from ever granting.
  always_comb begin
    w_fix_valid = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == SEL_WIDTH'(i)) begin
        w_fix_valid = in_valid[i];
      end
    end
  end

  always_comb begin
    w_grant       = '0;
    w_grant_valid = 1'b0;
    if (is_rr_mode(mode)) begin
      w_grant       = w_rr_grant;
      w_grant_valid = w_rr_valid;
    end else begin
      w_grant       = sel;
      w_grant_valid = w_fix_valid;
    end
  end

  assign w_can_load = !r_out_valid || out_ready;
  assign w_xfer     = w_can_load && w_grant_valid;

  always_comb begin
    w_in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_in_ready[i] = w_xfer && (w_grant == SEL_WIDTH'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_sel   <= '0;
      r_ptr       <= SEL_WIDTH'(CHANNELS - 1);
    end else if (w_xfer) begin
      r_out_data  <= w_words[w_grant];
      r_out_valid <= 1'b1;
      r_out_sel   <= w_grant;
      r_ptr       <= w_grant;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (4 channels x 64 bits) with hand-computed expectations.
module tb_stream_mux_rr;

  localparam int WS = 64;
  localparam int CH = 4;

  logic            clk;
  logic            reset;
  logic [CH*WS-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic            mode;
  logic [1:0]      sel;
  logic [WS-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_sel;

  int n_chk;
  int n_pass;

  logic [WS-1:0] words [CH];

  stream_mux_rr #(.WORDSIZE(WS), .CHANNELS(CH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    words[0] = 64'h1111;
    words[1] = 64'h2222;
    words[2] = 64'hBBBB;
    words[3] = 64'h4444;
    in_data   = {words[3], words[2], words[1], words[0]};
    reset     = 1'b1;
    in_valid  = '0;
    mode      = 1'b0;
    sel       = '0;
    out_ready = 1'b0;
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_sel", 64'(out_sel), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    step();
    step();
    reset = 1'b0;

    // Fixed select of channel 2
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    chk("fix_rdy", 64'(in_ready), 64'b0100);
    step();
    chk("fix_valid", 64'(out_valid), 64'd1);
    chk("fix_data", out_data, 64'hBBBB);
    chk("fix_sel", 64'(out_sel), 64'd2);
    sel = 2'd1; in_valid = 4'b1101;
    #1;
    chk("fix_norq", 64'(in_ready), 64'd0);
    step();
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_data", out_data, 64'hBBBB);
    chk("drain_sel", 64'(out_sel), 64'd2);

    // Load a word, then hit reset mid-cycle
    sel = 2'd3; in_valid = 4'b1111; out_ready = 1'b0;
    step();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_data", out_data, 64'h4444);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    chk("mid_rst_sel", 64'(out_sel), 64'd0);
    step();
    reset = 1'b0;

    // Round-robin with all channels valid: 0,1,2,3,0,...
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rr_rdy%0d", k), 64'(in_ready), 64'(4'b0001 << (k % 4)));
      step();
      chk($sformatf("rr_valid%0d", k), 64'(out_valid), 64'd1);
      chk($sformatf("rr_sel%0d", k), 64'(out_sel), 64'(k % 4));
      chk($sformatf("rr_data%0d", k), out_data, words[k % 4]);
    end

    // Round-robin skipping idle channels 0 and 2
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("skip_rdy%0d", k), 64'(in_ready), (k % 2 == 0) ? 64'b0010 : 64'b1000);
      step();
      chk($sformatf("skip_sel%0d", k), 64'(out_sel), (k % 2 == 0) ? 64'd1 : 64'd3);
    end

    // Backpressure: held word must not move while mode/sel wiggle
    in_valid = 4'b1111; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      mode = k[0];
      sel  = k[1:0];
      #1;
      chk($sformatf("bp_rdy%0d", k), 64'(in_ready), 64'd0);
      chk($sformatf("bp_sel%0d", k), 64'(out_sel), 64'd3);
      chk($sformatf("bp_data%0d", k), out_data, 64'h4444);
      chk($sformatf("bp_valid%0d", k), 64'(out_valid), 64'd1);
      step();
    end
    mode = 1'b1; out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", 64'(in_ready), 64'b0001);
    step();
    chk("bp_rel_valid", 64'(out_valid), 64'd1);
    chk("bp_rel_sel", 64'(out_sel), 64'd0);
    chk("bp_rel_data", out_data, 64'h1111);

    // Mode switching: rr grants 1, fixed picks 3, rr resumes at 0
    #1;
    chk("ms_rr_rdy", 64'(in_ready), 64'b0010);
    step();
    chk("ms_rr_sel", 64'(out_sel), 64'd1);
    mode = 1'b0; sel = 2'd3;
    #1;
    chk("ms_fix_rdy", 64'(in_ready), 64'b1000);
    step();
    chk("ms_fix_sel", 64'(out_sel), 64'd3);
    chk("ms_fix_data", out_data, 64'h4444);
    mode = 1'b1;
    #1;
    chk("ms_back_rdy", 64'(in_ready), 64'b0001);
    step();
    chk("ms_back_sel", 64'(out_sel), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
